// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a one-deep NoC packet send FSM.
// Optional completed-packet counter enabled by `define EX_MEM_PKT_CNT_EN.
module ex_mem_stage #(
  parameter int DEST_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegW_enable_E,
  input  logic              Mem_Write_E,
  input  logic              Mem_Read_E,
  input  logic              Result_src_E,
  input  logic [31:0]       alu_result_E,
  input  logic [31:0]       write_data_E,
  input  logic [4:0]        Radd_E,
  input  logic [31:0]       PC_E,
  input  logic              valid_E,
  input  logic              proc_valid_E,
  input  logic [DEST_W-1:0] dest_add_E,
  input  logic              flush_E,
  input  logic              stall_M,
  output logic              RegW_enable_M,
  output logic              Mem_Write_M,
  output logic              Mem_Read_M,
  output logic              Result_src_M,
  output logic [31:0]       alu_result_M,
  output logic [31:0]       write_data_M,
  output logic [4:0]        Radd_M,
  output logic [31:0]       PC_M,
  output logic              valid_M,
  output logic              stall_E,
  output logic              noc_valid,
  input  logic              noc_ready,
  output logic [DEST_W-1:0] noc_dest,
  output logic [31:0]       noc_data
`ifdef EX_MEM_PKT_CNT_EN
  ,
  output logic [15:0]       pkt_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic              regw_q, regw_d;
  logic              mw_q, mw_d;
  logic              mr_q, mr_d;
  logic              rs_q, rs_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       wd_q, wd_d;
  logic [4:0]        radd_q, radd_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [31:0]       data_q, data_d;

  logic capture;
  logic cap_valid;
  logic load_pkt;
  logic hshake;
  logic mem_en;

  assign stall_E   = stall_M | (state_q == SEND);
  assign capture   = ~stall_E;
  assign cap_valid = valid_E & ~flush_E;
  assign load_pkt  = capture & cap_valid & proc_valid_E;
  assign hshake    = (state_q == SEND) & noc_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load_pkt) state_d = SEND;
      SEND: if (hshake) state_d = IDLE;
    endcase
  end

  always_comb begin
    noc_valid = 1'b0;
    mem_en    = 1'b0;
    unique case (state_q)
      IDLE: mem_en    = 1'b1;
      SEND: noc_valid = 1'b1;
    endcase
  end

  // Held instruction stays frozen while SEND keeps stall_E high.
  always_comb begin
    regw_d  = regw_q;
    mw_d    = mw_q;
    mr_d    = mr_q;
    rs_d    = rs_q;
    alu_d   = alu_q;
    wd_d    = wd_q;
    radd_d  = radd_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (capture) begin
      valid_d = cap_valid;
      regw_d  = RegW_enable_E & ~flush_E;
      mw_d    = Mem_Write_E & ~flush_E;
      mr_d    = Mem_Read_E & ~flush_E;
      rs_d    = Result_src_E;
      alu_d   = alu_result_E;
      wd_d    = write_data_E;
      radd_d  = Radd_E;
      pc_d    = PC_E;
    end
    if (load_pkt) begin
      dest_d = dest_add_E;
      data_d = write_data_E;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regw_q  <= 1'b0;
      mw_q    <= 1'b0;
      mr_q    <= 1'b0;
      rs_q    <= 1'b0;
      alu_q   <= '0;
      wd_q    <= '0;
      radd_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      regw_q  <= regw_d;
      mw_q    <= mw_d;
      mr_q    <= mr_d;
      rs_q    <= rs_d;
      alu_q   <= alu_d;
      wd_q    <= wd_d;
      radd_q  <= radd_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign valid_M       = valid_q & mem_en;
  assign RegW_enable_M = regw_q & valid_M;
  assign Mem_Write_M   = mw_q & valid_M;
  assign Mem_Read_M    = mr_q & valid_M;
  assign Result_src_M  = rs_q & valid_M;
  assign alu_result_M  = alu_q;
  assign write_data_M  = wd_q;
  assign Radd_M        = radd_q;
  assign PC_M          = pc_q;
  assign noc_dest      = dest_q;
  assign noc_data      = data_q;

`ifdef EX_MEM_PKT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = hshake ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, reset corner, randomized
// traffic against a transaction-level model of the MEM slot and packet queue.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegW_enable_E, Mem_Write_E, Mem_Read_E, Result_src_E;
  logic [31:0] alu_result_E, write_data_E, PC_E;
  logic [4:0]  Radd_E;
  logic        valid_E, proc_valid_E, flush_E, stall_M;
  logic [1:0]  dest_add_E;
  logic        RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M;
  logic [31:0] alu_result_M, write_data_M, PC_M;
  logic [4:0]  Radd_M;
  logic        valid_M, stall_E, noc_valid, noc_ready;
  logic [1:0]  noc_dest;
  logic [31:0] noc_data;
`ifdef EX_MEM_PKT_CNT_EN
  logic [15:0] pkt_count;
`endif

  ex_mem_stage #(.DEST_W(2)) dut (
    .clk(clk), .rst(rst),
    .RegW_enable_E(RegW_enable_E), .Mem_Write_E(Mem_Write_E),
    .Mem_Read_E(Mem_Read_E), .Result_src_E(Result_src_E),
    .alu_result_E(alu_result_E), .write_data_E(write_data_E),
    .Radd_E(Radd_E), .PC_E(PC_E), .valid_E(valid_E),
    .proc_valid_E(proc_valid_E), .dest_add_E(dest_add_E),
    .flush_E(flush_E), .stall_M(stall_M),
    .RegW_enable_M(RegW_enable_M), .Mem_Write_M(Mem_Write_M),
    .Mem_Read_M(Mem_Read_M), .Result_src_M(Result_src_M),
    .alu_result_M(alu_result_M), .write_data_M(write_data_M),
    .Radd_M(Radd_M), .PC_M(PC_M), .valid_M(valid_M),
    .stall_E(stall_E), .noc_valid(noc_valid), .noc_ready(noc_ready),
    .noc_dest(noc_dest), .noc_data(noc_data)
`ifdef EX_MEM_PKT_CNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the instruction occupying MEM, plus the packets still owed.
  typedef struct {
    logic        v, regw, mw, mr, rs;
    logic [31:0] alu, wd, pc;
    logic [4:0]  rd;
  } ins_t;
  typedef struct {
    logic [1:0]  dst;
    logic [31:0] data;
  } pkt_t;

  ins_t        m;
  pkt_t        pq[$];
  pkt_t        last_pkt;
  int unsigned cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '{default: '0};
    pq.delete();
    last_pkt = '{default: '0};
    cnt = 0;
  endtask

  task automatic model_edge();
    bit busy;
    pkt_t p;
    busy = stall_M || (pq.size() != 0);
    if (pq.size() != 0 && noc_ready) begin
      void'(pq.pop_front());
      cnt++;
    end
    if (!busy) begin
      m.v    = valid_E && !flush_E;
      m.regw = RegW_enable_E && !flush_E;
      m.mw   = Mem_Write_E && !flush_E;
      m.mr   = Mem_Read_E && !flush_E;
      m.rs   = Result_src_E;
      m.alu  = alu_result_E;
      m.wd   = write_data_E;
      m.pc   = PC_E;
      m.rd   = Radd_E;
      if (m.v && proc_valid_E) begin
        p.dst = dest_add_E;
        p.data = write_data_E;
        pq.push_back(p);
        last_pkt = p;
      end
    end
  endtask

  task automatic check_all();
    logic ev;
    logic snd;
    snd = (pq.size() != 0);
    ev = m.v && !snd;
    chk("valid_M", valid_M, ev);
    chk("RegW_M", RegW_enable_M, m.regw & ev);
    chk("MemW_M", Mem_Write_M, m.mw & ev);
    chk("MemR_M", Mem_Read_M, m.mr & ev);
    chk("ResSrc_M", Result_src_M, m.rs & ev);
    chk("alu_M", alu_result_M, m.alu);
    chk("wdata_M", write_data_M, m.wd);
    chk("Radd_M", Radd_M, m.rd);
    chk("PC_M", PC_M, m.pc);
    chk("noc_valid", noc_valid, snd);
    chk("stall_E", stall_E, stall_M | snd);
    chk("noc_dest", noc_dest, last_pkt.dst);
    chk("noc_data", noc_data, last_pkt.data);
`ifdef EX_MEM_PKT_CNT_EN
    chk("pkt_count", pkt_count, cnt[15:0]);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(logic v, logic pv, logic fl, logic sm, logic rdy,
                        logic mw, logic [31:0] alu, logic [31:0] wd,
                        logic [4:0] rd, logic [1:0] dst);
    valid_E = v; proc_valid_E = pv; flush_E = fl; stall_M = sm;
    noc_ready = rdy; Mem_Write_E = mw; alu_result_E = alu;
    write_data_E = wd; Radd_E = rd; dest_add_E = dst;
    RegW_enable_E = 1'b1; Mem_Read_E = 1'b0; Result_src_E = 1'b0;
    PC_E = alu + 32'h1000;
  endtask

  typedef struct {
    logic        v, pv, fl, sm, rdy, mw;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic [1:0]  dst;
    logic        evm, env, ese, emw;
    logic [31:0] ealu;
    logic [1:0]  edst;
    logic [31:0] edata;
  } vec_t;

  function automatic vec_t mk(logic v, logic pv, logic fl, logic sm,
                              logic rdy, logic mw, logic [31:0] alu,
                              logic [31:0] wd, logic [4:0] rd,
                              logic [1:0] dst, logic evm, logic env,
                              logic ese, logic emw, logic [31:0] ealu,
                              logic [1:0] edst, logic [31:0] edata);
    vec_t r;
    r.v = v; r.pv = pv; r.fl = fl; r.sm = sm; r.rdy = rdy; r.mw = mw;
    r.alu = alu; r.wd = wd; r.rd = rd; r.dst = dst;
    r.evm = evm; r.env = env; r.ese = ese; r.emw = emw;
    r.ealu = ealu; r.edst = edst; r.edata = edata;
    return r;
  endfunction

  vec_t vt[12];

  initial begin
    vt[0]  = mk(1,0,0,0,0,0, 32'h10, 32'h0, 5, 0,  1,0,0,0, 32'h10, 0, 32'h0);
    vt[1]  = mk(1,1,0,0,0,0, 32'h20, 32'hDEADBEEF, 6, 2,
                0,1,1,0, 32'h20, 2, 32'hDEADBEEF);
    vt[2]  = mk(1,1,0,0,0,1, 32'h30, 32'h11111111, 7, 1,
                0,1,1,0, 32'h20, 2, 32'hDEADBEEF);
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = mk(1,0,0,0,1,0, 32'h50, 32'h0, 8, 0,
                1,0,0,0, 32'h20, 2, 32'hDEADBEEF);
    vt[6]  = mk(1,0,1,0,0,1, 32'h60, 32'h0, 9, 0,
                0,0,0,0, 32'h60, 2, 32'hDEADBEEF);
    vt[7]  = mk(1,1,0,0,0,1, 32'h70, 32'hCAFEF00D, 10, 3,
                0,1,1,0, 32'h70, 3, 32'hCAFEF00D);
    vt[8]  = mk(1,0,1,0,0,1, 32'h80, 32'h0, 11, 0,
                0,1,1,0, 32'h70, 3, 32'hCAFEF00D);
    vt[9]  = mk(1,0,1,0,1,1, 32'h90, 32'h0, 12, 0,
                1,0,0,1, 32'h70, 3, 32'hCAFEF00D);
    vt[10] = mk(1,0,0,1,0,0, 32'hA0, 32'h0, 13, 0,
                1,0,1,1, 32'h70, 3, 32'hCAFEF00D);
    vt[11] = mk(0,0,0,0,0,0, 32'hB0, 32'h0, 14, 0,
                0,0,0,0, 32'hB0, 3, 32'hCAFEF00D);

    rst = 1'b1;
    set_in(0,0,0,0,0,0, 32'h0, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].v, vt[i].pv, vt[i].fl, vt[i].sm, vt[i].rdy, vt[i].mw,
             vt[i].alu, vt[i].wd, vt[i].rd, vt[i].dst);
      cyc();
      chk($sformatf("vec%0d.valid_M", i), valid_M, vt[i].evm);
      chk($sformatf("vec%0d.noc_valid", i), noc_valid, vt[i].env);
      chk($sformatf("vec%0d.stall_E", i), stall_E, vt[i].ese);
      chk($sformatf("vec%0d.MemW_M", i), Mem_Write_M, vt[i].emw);
      chk($sformatf("vec%0d.alu_M", i), alu_result_M, vt[i].ealu);
      chk($sformatf("vec%0d.noc_dest", i), noc_dest, vt[i].edst);
      chk($sformatf("vec%0d.noc_data", i), noc_data, vt[i].edata);
    end

    // Reset while a packet is being offered.
    set_in(1,1,0,0,0,0, 32'hC0, 32'h12345678, 3, 1);
    cyc();
    chk("pre_rst.noc_valid", noc_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst.noc_valid", noc_valid, 1'b0);
    chk("rst.valid_M", valid_M, 1'b0);
    chk("rst.stall_E", stall_E, 1'b0);
    chk("rst.noc_data", noc_data, 32'h0);
    chk("rst.alu_M", alu_result_M, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1,0,0,0,1,0, 32'hD0, 32'h0, 9, 0);
    cyc();
    chk("post_rst.valid_M", valid_M, 1'b1);
    chk("post_rst.alu_M", alu_result_M, 32'hD0);
    chk("post_rst.Radd_M", Radd_M, 32'd9);
    chk("post_rst.noc_valid", noc_valid, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      valid_E       = ($urandom_range(0, 3) != 0);
      proc_valid_E  = ($urandom_range(0, 2) == 0);
      flush_E       = ($urandom_range(0, 7) == 0);
      stall_M       = ($urandom_range(0, 4) == 0);
      noc_ready     = $urandom_range(0, 1);
      RegW_enable_E = $urandom_range(0, 1);
      Mem_Write_E   = $urandom_range(0, 1);
      Mem_Read_E    = $urandom_range(0, 1);
      Result_src_E  = $urandom_range(0, 1);
      alu_result_E  = $urandom;
      write_data_E  = $urandom;
      PC_E          = $urandom;
      Radd_E        = 5'($urandom);
      dest_add_E    = 2'($urandom);
      cyc();
    end

`ifdef EX_MEM_PKT_CNT_EN
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(1,1,0,0,1,0, 32'h100 + k, 32'hA0 + k, 1, 2'(k));
      cyc();
      set_in(0,0,0,0,1,0, 32'h0, 32'h0, 0, 0);
      cyc();
    end
    chk("cnt3", pkt_count, 32'd3);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    cnt = 32'hFFFF;
    set_in(1,1,0,0,1,0, 32'h200, 32'hBB, 1, 1);
    cyc();
    set_in(0,0,0,0,1,0, 32'h0, 32'h0, 0, 0);
    cyc();
    chk("cnt_wrap", pkt_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
